led_sequence_controller: RTL and testbench

Front-panel controller for the four switches and four LEDs on the board. It debounces each switch internally and turns switch releases into one-cycle command events. A mode state machine uses those events to drive a registered LED pattern: off, static, blink or chase. It replaces the single-switch toggle logic at the top level and is the only block allowed to drive o_LED_1..4.

---
 rtl/led_sequence_controller.sv | 164 ++++++++++++++++
 tb/tb_led_sequence_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequence_controller.sv
// led_sequence_controller: front-panel block for four switches and four LEDs.
// Each switch is debounced and its release becomes a one-cycle command event.
// A mode state machine (OFF/STATIC/BLINK/CHASE) uses those events to drive a
// registered LED pattern whose timing comes from a shared tick divider.
module led_sequence_controller #(
  parameter int DEBOUNCE_LIMIT = 20,
  parameter int TICK_DIV       = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  // Switch bit 0 is S1 (next), 1 is S2 (previous), 2 is S3 (pause), 3 is S4 (restart).
  logic [3:0]            w_raw;
  logic [3:0]            r_deb;
  logic [3:0]            r_deb_d;
  logic [3:0][DB_W-1:0]  r_db_cnt;
  logic [3:0]            w_release;

  mode_t                 r_mode;
  mode_t                 w_mode_next;
  logic                  r_pause;
  logic                  w_pause_next;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [TICK_W-1:0]     w_tick_cnt_next;
  logic                  r_phase;
  logic                  w_phase_next;
  logic [3:0]            r_chase;
  logic [3:0]            w_chase_next;
  logic [3:0]            r_led;
  logic [3:0]            w_led_next;
  logic                  w_mode_chg;
  logic                  w_restart;
  logic                  w_animated;
  logic                  w_tick;

  assign w_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Per-switch debounce: a level must differ for DEBOUNCE_LIMIT samples in a row.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would let one register see another's new value mid-block.
    if (i_Rst) begin
      // NOTE: the counters are ordinary flops, not a RAM, so reset can clear
      // them; this is what discards a half-qualified press held through reset.
      r_deb    <= '0;
      r_deb_d  <= '0;
      r_db_cnt <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (w_raw[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= w_raw[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A release is the debounced level falling; presses produce nothing.
  assign w_release = ~r_deb & r_deb_d;

  // Mode state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_mode <= MODE_OFF;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Next mode, pause, tick divider and pattern state from the command events.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_mode_next     = r_mode;
    w_pause_next    = r_pause ^ w_release[2];
    w_tick_cnt_next = r_tick_cnt;
    w_phase_next    = r_phase;
    w_chase_next    = r_chase;

    // S1 and S2 together cancel out.
    case (w_release[1:0])
      2'b01:   w_mode_next = mode_t'(r_mode + 2'd1);
      2'b10:   w_mode_next = mode_t'(r_mode - 2'd1);
      default: w_mode_next = r_mode;
    endcase

    w_mode_chg = w_release[0] ^ w_release[1];
    w_restart  = w_mode_chg | w_release[3];
    w_animated = (r_mode == MODE_BLINK) || (r_mode == MODE_CHASE);
    w_tick     = w_animated && !r_pause && (r_tick_cnt == TICK_LAST);

    if (w_restart || !w_animated) begin
      w_tick_cnt_next = '0;
    end else if (!r_pause) begin
      w_tick_cnt_next = w_tick ? '0 : r_tick_cnt + 1'b1;
    end

    if (w_restart) begin
      w_phase_next = 1'b1;
      w_chase_next = 4'b0001;
    end else if (w_tick) begin
      if (r_mode == MODE_BLINK) w_phase_next = ~r_phase;
      if (r_mode == MODE_CHASE) w_chase_next = {r_chase[2:0], r_chase[3]};
    end

    case (r_mode)
      MODE_OFF:    w_led_next = 4'b0000;
      MODE_STATIC: w_led_next = 4'b1111;
      MODE_BLINK:  w_led_next = {4{r_phase}};
      default:     w_led_next = r_chase;
    endcase
  end

  // Pattern registers and the registered LED drive.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_pause    <= 1'b0;
      r_tick_cnt <= '0;
      r_phase    <= 1'b1;
      r_chase    <= 4'b0001;
      r_led      <= 4'b0000;
    end else begin
      r_pause    <= w_pause_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_phase    <= w_phase_next;
      r_chase    <= w_chase_next;
      r_led      <= w_led_next;
    end
  end

  assign o_Mode  = r_mode;
  assign o_LED_1 = r_led[0];
  assign o_LED_2 = r_led[1];
  assign o_LED_3 = r_led[2];
  assign o_LED_4 = r_led[3];

endmodule

// File: tb/tb_led_sequence_controller.sv
// Bench for led_sequence_controller with DEBOUNCE_LIMIT=4, TICK_DIV=8.
// A behavioural model (mode number, ticks-since-restart) is checked against
// the DUT every cycle; directed literal expectations pin the model's timing.
module tb_led_sequence_controller;

  localparam int DL = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0000;
  logic       led_1, led_2, led_3, led_4;
  logic [1:0] mode;
  logic [3:0] leds;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  assign leds = {led_4, led_3, led_2, led_1};

  always #5 clk = ~clk;

  led_sequence_controller #(.DEBOUNCE_LIMIT(DL), .TICK_DIV(TD)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .o_LED_1   (led_1),
    .o_LED_2   (led_2),
    .o_LED_3   (led_3),
    .o_LED_4   (led_4),
    .o_Mode    (mode)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_run[4];
  bit [3:0]   m_deb, m_debd, m_ev;
  int         m_mode, m_elapsed, m_steps;
  bit         m_pause;
  logic [3:0] m_led = 4'b0000;

  // LED pattern as a function of mode and ticks since the last restart.
  function automatic logic [3:0] pattern(input int md, input int steps);
    case (md)
      0:       return 4'b0000;
      1:       return 4'b1111;
      2:       return (steps % 2 == 0) ? 4'b1111 : 4'b0000;
      default: return 4'(1 << (steps % 4));
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_deb = '0; m_debd = '0;
      m_mode = 0; m_elapsed = 0; m_steps = 0; m_pause = 0;
      m_led = 4'b0000;
    end else begin
      m_ev  = ~m_deb & m_debd;
      m_led = pattern(m_mode, m_steps);
      m_debd = m_deb;
      for (int i = 0; i < 4; i++) begin
        if (sw[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DL) begin
            m_deb[i] = sw[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if ((m_ev[0] ^ m_ev[1]) || m_ev[3]) begin
        m_elapsed = 0;
        m_steps   = 0;
      end else if (m_mode >= 2) begin
        if (!m_pause) begin
          if (m_elapsed == TD - 1) begin
            m_elapsed = 0;
            m_steps++;
          end else begin
            m_elapsed++;
          end
        end
      end else begin
        m_elapsed = 0;
      end
      if (m_ev[0] && !m_ev[1]) m_mode = (m_mode + 1) % 4;
      if (m_ev[1] && !m_ev[0]) m_mode = (m_mode + 3) % 4;
      m_pause = m_pause ^ m_ev[2];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_mode", 8'(mode), 8'(m_mode));
      check("model_led", 8'(leds), 8'(m_led));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a switch mask long enough to qualify, then release it.
  task automatic press(input logic [3:0] m);
    sw = m;
    step(6);
    sw = 4'b0000;
  endtask

  task automatic wait_led(input logic [3:0] val, input string name);
    int n = 0;
    while (leds !== val && n < 40) begin
      step(1);
      n++;
    end
    check(name, 8'(leds), 8'(val));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1);
      cmp_en = 1'b1;
      check("rst_led", 8'(leds), 8'h00);
      check("rst_mode", 8'(mode), 8'h00);
    end
    rst = 1'b0;

    // Glitch shorter than the debounce window.
    sw = 4'b0001; step(3); sw = 4'b0000; step(10);
    check("glitch_mode", 8'(mode), 8'h00);

    // Qualified S1: mode on the 5th edge after release, LEDs one edge later.
    sw = 4'b0001; step(10); sw = 4'b0000;
    step(4); check("s1_mode_early", 8'(mode), 8'h00);
    step(1); check("s1_mode", 8'(mode), 8'h01);
    check("s1_led_early", 8'(leds), 8'h00);
    step(1); check("s1_led", 8'(leds), 8'h0F);
    step(3);

    // Wrap forward, then backward from OFF.
    press(4'b0001); step(5); check("wrap_2", 8'(mode), 8'h02);
    press(4'b0001); step(5); check("wrap_3", 8'(mode), 8'h03);
    press(4'b0001); step(5); check("wrap_0", 8'(mode), 8'h00);
    press(4'b0010); step(5); check("s2_mode", 8'(mode), 8'h03);
    step(1); check("s2_led", 8'(leds), 8'h01);
    press(4'b0011); step(5); check("s1s2_mode", 8'(mode), 8'h03);
    step(2);

    // Chase after a restart: 8-cycle steps.
    press(4'b1000); step(5);
    step(1); check("chase_0", 8'(leds), 8'h01);
    step(7); check("chase_0_hold", 8'(leds), 8'h01);
    step(1); check("chase_1", 8'(leds), 8'h02);

    // Pause mid-interval, hold, resume with the remaining count.
    press(4'b0100); step(5);
    step(40); check("pause_hold", 8'(leds), 8'h04);
    press(4'b0100);
    step(9); check("resume_early", 8'(leds), 8'h04);
    step(1); check("resume_step", 8'(leds), 8'h08);

    // Blink.
    press(4'b0010); step(5); check("blink_mode", 8'(mode), 8'h02);
    step(1); check("blink_on", 8'(leds), 8'h0F);
    step(7); check("blink_on_hold", 8'(leds), 8'h0F);
    step(1); check("blink_off", 8'(leds), 8'h00);

    // S4 released at the start of an off phase restarts to on.
    sw = 4'b1000; step(6);
    wait_led(4'b1111, "wait_on");
    wait_led(4'b0000, "wait_off");
    sw = 4'b0000;
    step(5); check("s4_before", 8'(leds), 8'h00);
    step(1); check("s4_on", 8'(leds), 8'h0F);
    step(7); check("s4_on_hold", 8'(leds), 8'h0F);
    step(1); check("s4_off", 8'(leds), 8'h00);

    // S4 with S1 together: mode change plus restart.
    press(4'b1001); step(5); check("s4s1_mode", 8'(mode), 8'h03);
    step(1); check("s4s1_led", 8'(leds), 8'h01);

    // Reset while S1 is partly qualified, S1 held through reset.
    sw = 4'b0001; step(2);
    rst = 1'b1;
    step(1); check("mid_rst_mode", 8'(mode), 8'h00);
    check("mid_rst_led", 8'(leds), 8'h00);
    step(1);
    rst = 1'b0;
    step(6); check("post_rst_mode", 8'(mode), 8'h00);
    sw = 4'b0000;
    step(4); check("post_rst_early", 8'(mode), 8'h00);
    step(1); check("post_rst_s1", 8'(mode), 8'h01);
    step(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
